// File: rtl/rvfi_pkg.sv
// RVFI completion-packet layout shared by the core wrapper and the retire ROB.
// Fields sit at fixed bit offsets inside a flat PKT_W vector.
package rvfi_pkg;

    localparam int unsigned PKG_XLEN = 32;
    localparam int unsigned INSN_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned MASK_W   = PKG_XLEN / 8;

    localparam int unsigned OFF_MEM_WMASK = 0;
    localparam int unsigned OFF_MEM_RMASK = OFF_MEM_WMASK + MASK_W;
    localparam int unsigned OFF_MEM_WDATA = OFF_MEM_RMASK + MASK_W;
    localparam int unsigned OFF_MEM_RDATA = OFF_MEM_WDATA + PKG_XLEN;
    localparam int unsigned OFF_MEM_ADDR  = OFF_MEM_RDATA + PKG_XLEN;
    localparam int unsigned OFF_RD_WDATA  = OFF_MEM_ADDR + PKG_XLEN;
    localparam int unsigned OFF_RS2_RDATA = OFF_RD_WDATA + PKG_XLEN;
    localparam int unsigned OFF_RS1_RDATA = OFF_RS2_RDATA + PKG_XLEN;
    localparam int unsigned OFF_RD_ADDR   = OFF_RS1_RDATA + PKG_XLEN;
    localparam int unsigned OFF_RS2_ADDR  = OFF_RD_ADDR + REG_W;
    localparam int unsigned OFF_RS1_ADDR  = OFF_RS2_ADDR + REG_W;
    localparam int unsigned OFF_POST_PC   = OFF_RS1_ADDR + REG_W;
    localparam int unsigned OFF_PC_RDATA  = OFF_POST_PC + PKG_XLEN;
    localparam int unsigned OFF_TRAP      = OFF_PC_RDATA + PKG_XLEN;
    localparam int unsigned OFF_INSN      = OFF_TRAP + 1;
    localparam int unsigned PKT_W         = OFF_INSN + INSN_W;

    typedef logic [PKT_W-1:0] rvfi_pkt_t;

    typedef struct packed {
        logic [INSN_W-1:0]   insn;
        logic                trap;
        logic [PKG_XLEN-1:0] pc_rdata;
        logic [PKG_XLEN-1:0] post_pc;
        logic [REG_W-1:0]    rs1_addr;
        logic [REG_W-1:0]    rs2_addr;
        logic [REG_W-1:0]    rd_addr;
        logic [PKG_XLEN-1:0] rs1_rdata;
        logic [PKG_XLEN-1:0] rs2_rdata;
        logic [PKG_XLEN-1:0] rd_wdata;
        logic [PKG_XLEN-1:0] mem_addr;
        logic [PKG_XLEN-1:0] mem_rdata;
        logic [PKG_XLEN-1:0] mem_wdata;
        logic [MASK_W-1:0]   mem_rmask;
        logic [MASK_W-1:0]   mem_wmask;
    } rvfi_rec_t;

    function automatic rvfi_pkt_t rvfi_pack(input rvfi_rec_t r);
        rvfi_pkt_t p;
        p = '0;
        p[OFF_INSN      +: INSN_W]   = r.insn;
        p[OFF_TRAP]                  = r.trap;
        p[OFF_PC_RDATA  +: PKG_XLEN] = r.pc_rdata;
        p[OFF_POST_PC   +: PKG_XLEN] = r.post_pc;
        p[OFF_RS1_ADDR  +: REG_W]    = r.rs1_addr;
        p[OFF_RS2_ADDR  +: REG_W]    = r.rs2_addr;
        p[OFF_RD_ADDR   +: REG_W]    = r.rd_addr;
        p[OFF_RS1_RDATA +: PKG_XLEN] = r.rs1_rdata;
        p[OFF_RS2_RDATA +: PKG_XLEN] = r.rs2_rdata;
        p[OFF_RD_WDATA  +: PKG_XLEN] = r.rd_wdata;
        p[OFF_MEM_ADDR  +: PKG_XLEN] = r.mem_addr;
        p[OFF_MEM_RDATA +: PKG_XLEN] = r.mem_rdata;
        p[OFF_MEM_WDATA +: PKG_XLEN] = r.mem_wdata;
        p[OFF_MEM_RMASK +: MASK_W]   = r.mem_rmask;
        p[OFF_MEM_WMASK +: MASK_W]   = r.mem_wmask;
        return p;
    endfunction

    function automatic rvfi_rec_t rvfi_unpack(input rvfi_pkt_t p);
        rvfi_rec_t r;
        r.insn      = p[OFF_INSN      +: INSN_W];
        r.trap      = p[OFF_TRAP];
        r.pc_rdata  = p[OFF_PC_RDATA  +: PKG_XLEN];
        r.post_pc   = p[OFF_POST_PC   +: PKG_XLEN];
        r.rs1_addr  = p[OFF_RS1_ADDR  +: REG_W];
        r.rs2_addr  = p[OFF_RS2_ADDR  +: REG_W];
        r.rd_addr   = p[OFF_RD_ADDR   +: REG_W];
        r.rs1_rdata = p[OFF_RS1_RDATA +: PKG_XLEN];
        r.rs2_rdata = p[OFF_RS2_RDATA +: PKG_XLEN];
        r.rd_wdata  = p[OFF_RD_WDATA  +: PKG_XLEN];
        r.mem_addr  = p[OFF_MEM_ADDR  +: PKG_XLEN];
        r.mem_rdata = p[OFF_MEM_RDATA +: PKG_XLEN];
        r.mem_wdata = p[OFF_MEM_WDATA +: PKG_XLEN];
        r.mem_rmask = p[OFF_MEM_RMASK +: MASK_W];
        r.mem_wmask = p[OFF_MEM_WMASK +: MASK_W];
        return r;
    endfunction

endpackage

// File: rtl/rvfi_rob_mem.sv
// ROB packet storage: one write port for completions, one asynchronous read
// port that always presents the head entry.
module rvfi_rob_mem #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned W     = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    // Payload only; validity lives in the owner's done bits, so no reset here.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rvfi_retire_rob.sv
// RVFI retire reorder buffer: out-of-order completions in, one in-order RVFI
// channel out. Optional flush port enabled by defining RVFI_ROB_FLUSH_EN.
module rvfi_retire_rob
    import rvfi_pkg::*;
#(
    parameter  int unsigned XLEN    = PKG_XLEN,  // must equal rvfi_pkg::PKG_XLEN
    parameter  int unsigned DEPTH   = 8,
    parameter  int unsigned ORDER_W = 64,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned MW      = XLEN / 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    output logic [AW-1:0]      alloc_tag,
    input  logic               cmp_valid,
    input  logic [AW-1:0]      cmp_tag,
    input  logic [PKT_W-1:0]   cmp_pkt,
`ifdef RVFI_ROB_FLUSH_EN
    input  logic               flush,
`endif
    output logic               err,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [31:0]        rvfi_insn,
    output logic               rvfi_trap,
    output logic [XLEN-1:0]    rvfi_pc_rdata,
    output logic [XLEN-1:0]    rvfi_post_pc,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [XLEN-1:0]    rvfi_rs1_rdata,
    output logic [XLEN-1:0]    rvfi_rs2_rdata,
    output logic [XLEN-1:0]    rvfi_rd_wdata,
    output logic [XLEN-1:0]    rvfi_mem_addr,
    output logic [XLEN-1:0]    rvfi_mem_rdata,
    output logic [XLEN-1:0]    rvfi_mem_wdata,
    output logic [MW-1:0]      rvfi_mem_rmask,
    output logic [MW-1:0]      rvfi_mem_wmask
);

    logic [AW:0]        head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]   done_q, done_d, alloc_q, alloc_d;
    logic [ORDER_W-1:0] cnt_q, cnt_d, order_q, order_d;
    logic               err_q, err_d, valid_q, valid_d;
    rvfi_rec_t          out_q, out_d;

    logic [AW-1:0] head_idx, tail_idx;
    logic          full, flush_w, alloc_ok, do_alloc, cmp_legal, do_cmp, do_retire;
    rvfi_pkt_t     head_pkt;

`ifdef RVFI_ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign head_idx    = head_q[AW-1:0];
    assign tail_idx    = tail_q[AW-1:0];
    assign full        = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    // Legality looks at the same-cycle allocation so a core may complete an
    // instruction in the very cycle it is allocated.
    assign alloc_ok  = alloc_valid && !full;
    assign do_alloc  = alloc_ok && !flush_w;
    assign cmp_legal = (alloc_q[cmp_tag] || (alloc_ok && (cmp_tag == tail_idx)))
                       && !done_q[cmp_tag];
    assign do_cmp    = cmp_valid && cmp_legal && !flush_w;
    assign do_retire = done_q[head_idx] && !flush_w;

    rvfi_rob_mem #(
        .DEPTH (DEPTH),
        .W     (PKT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_cmp),
        .waddr_i (cmp_tag),
        .wdata_i (cmp_pkt),
        .raddr_i (head_idx),
        .rdata_o (head_pkt)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        done_d  = done_q;
        alloc_d = alloc_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = err_q | (cmp_valid && !cmp_legal);
        if (flush_w) begin
            tail_d  = head_q;
            done_d  = '0;
            alloc_d = '0;
        end else begin
            if (do_retire) begin
                done_d[head_idx]  = 1'b0;
                alloc_d[head_idx] = 1'b0;
                head_d  = head_q + 1'b1;
                order_d = cnt_q;
                cnt_d   = cnt_q + 1'b1;
                out_d   = rvfi_unpack(head_pkt);
                valid_d = 1'b1;
            end
            if (do_alloc) begin
                alloc_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                tail_d = tail_q + 1'b1;
            end
            if (do_cmp) done_d[cmp_tag] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            done_q  <= '0;
            alloc_q <= '0;
            cnt_q   <= '0;
            order_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            done_q  <= done_d;
            alloc_q <= alloc_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign err            = err_q;
    assign rvfi_valid     = valid_q;
    assign rvfi_order     = order_q;
    assign rvfi_insn      = out_q.insn;
    assign rvfi_trap      = out_q.trap;
    assign rvfi_pc_rdata  = out_q.pc_rdata;
    assign rvfi_post_pc   = out_q.post_pc;
    assign rvfi_rs1_addr  = out_q.rs1_addr;
    assign rvfi_rs2_addr  = out_q.rs2_addr;
    assign rvfi_rd_addr   = out_q.rd_addr;
    assign rvfi_rs1_rdata = out_q.rs1_rdata;
    assign rvfi_rs2_rdata = out_q.rs2_rdata;
    assign rvfi_rd_wdata  = out_q.rd_wdata;
    assign rvfi_mem_addr  = out_q.mem_addr;
    assign rvfi_mem_rdata = out_q.mem_rdata;
    assign rvfi_mem_wdata = out_q.mem_wdata;
    assign rvfi_mem_rmask = out_q.mem_rmask;
    assign rvfi_mem_wmask = out_q.mem_wmask;

endmodule

// File: tb/tb_rvfi_retire_rob.sv
// Directed bench for rvfi_retire_rob: in-order/out-of-order retire, full,
// protocol errors, async reset, and flush when RVFI_ROB_FLUSH_EN is defined.
module tb_rvfi_retire_rob;
    import rvfi_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 3;

    logic              clk, resetn;
    logic              alloc_valid, alloc_ready;
    logic [AW-1:0]     alloc_tag;
    logic              cmp_valid;
    logic [AW-1:0]     cmp_tag;
    logic [PKT_W-1:0]  cmp_pkt;
`ifdef RVFI_ROB_FLUSH_EN
    logic              flush;
`endif
    logic              err, rvfi_valid, rvfi_trap;
    logic [63:0]       rvfi_order;
    logic [31:0]       rvfi_insn;
    logic [XLEN-1:0]   rvfi_pc_rdata, rvfi_post_pc, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [XLEN-1:0]   rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4:0]        rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]        rvfi_mem_rmask, rvfi_mem_wmask;

    int n_chk = 0;
    int n_pass = 0;

    rvfi_retire_rob dut (
        .clk(clk), .resetn(resetn),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_pkt(cmp_pkt),
`ifdef RVFI_ROB_FLUSH_EN
        .flush(flush),
`endif
        .err(err), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_post_pc(rvfi_post_pc),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cmp_valid   = 1'b0;
    endtask

    // Packet k: every field derived from k so each retire is recognisable.
    task automatic complete(input int tag, input int k);
        rvfi_rec_t r;
        r           = '0;
        r.insn      = 32'hA000_0000 + k;
        r.trap      = k[0];
        r.pc_rdata  = 32'h0000_1000 + 4 * k;
        r.post_pc   = 32'h0000_1004 + 4 * k;
        r.rd_addr   = k[4:0];
        r.rd_wdata  = 32'hD000_0000 + k;
        r.mem_wmask = 4'hF;
        cmp_valid = 1'b1;
        cmp_tag   = tag[AW-1:0];
        cmp_pkt   = rvfi_pack(r);
    endtask

    task automatic chk_ret(input string tag, input int ord, input int k);
        check({tag, ".valid"}, rvfi_valid, 1);
        check({tag, ".order"}, rvfi_order, ord);
        check({tag, ".insn"}, rvfi_insn, 32'hA000_0000 + k);
        check({tag, ".trap"}, rvfi_trap, k % 2);
        check({tag, ".post_pc"}, rvfi_post_pc, 32'h0000_1004 + 4 * k);
        check({tag, ".rd_wdata"}, rvfi_rd_wdata, 32'hD000_0000 + k);
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        alloc_valid = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] t;
        resetn = 1'b1;
`ifdef RVFI_ROB_FLUSH_EN
        flush = 1'b0;
`endif
        cmp_tag = '0;
        cmp_pkt = '0;
        idle();
        #3 resetn = 1'b0;
        cyc();
        cyc();
        check("rst.valid", rvfi_valid, 0);
        check("rst.order", rvfi_order, 0);
        check("rst.ready", alloc_ready, 1);
        check("rst.tag", alloc_tag, 0);
        check("rst.err", err, 0);
        check("rst.insn", rvfi_insn, 0);
        resetn = 1'b1;

        // In-order completion: each retires one cycle after its completion.
        alloc_valid = 1'b1;
        check("t1.tag0", alloc_tag, 0);
        cyc();
        check("t1.tag1", alloc_tag, 1);
        cyc();
        check("t1.tag2", alloc_tag, 2);
        cyc();
        alloc_valid = 1'b0;
        complete(0, 1);
        cyc();
        check("t1.nobypass", rvfi_valid, 0);
        complete(1, 2);
        cyc();
        chk_ret("t1.r0", 0, 1);
        complete(2, 3);
        cyc();
        chk_ret("t1.r1", 1, 2);
        idle();
        cyc();
        chk_ret("t1.r2", 2, 3);
        cyc();
        check("t1.quiet", rvfi_valid, 0);
        check("t1.err", err, 0);

        // Completion in the same cycle as allocation (tag 3).
        alloc_valid = 1'b1;
        complete(3, 4);
        cyc();
        idle();
        check("same.err", err, 0);
        check("same.valid", rvfi_valid, 0);
        cyc();
        chk_ret("same.r", 3, 4);

        // Out-of-order completion 3,2,1 then 0.
        do_reset();
        alloc_n(4);
        complete(3, 13);
        cyc();
        check("t2.hold3", rvfi_valid, 0);
        complete(2, 12);
        cyc();
        check("t2.hold2", rvfi_valid, 0);
        complete(1, 11);
        cyc();
        check("t2.hold1", rvfi_valid, 0);
        complete(0, 10);
        cyc();
        check("t2.hold0", rvfi_valid, 0);
        idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_ret($sformatf("t2.r%0d", i), i, 10 + i);
        end
        cyc();
        check("t2.quiet", rvfi_valid, 0);

        // Full ROB, retire frees a slot only on the following cycle.
        do_reset();
        alloc_n(8);
        check("t3.full", alloc_ready, 0);
        alloc_valid = 1'b1;
        complete(0, 20);
        cyc();
        check("t3.still_full", alloc_ready, 0);
        cmp_valid = 1'b0;
        cyc();
        chk_ret("t3.r0", 0, 20);
        check("t3.freed", alloc_ready, 1);
        check("t3.refused", alloc_tag, 0);
        cyc();
        check("t3.accepted", alloc_ready, 0);
        idle();

        // Protocol errors leave the ROB contents untouched.
        do_reset();
        alloc_n(2);
        complete(5, 30);
        cyc();
        check("t4.err_unalloc", err, 1);
        check("t4.tag", alloc_tag, 2);
        complete(1, 31);
        cyc();
        check("t4.err_sticky", err, 1);
        check("t4.noret", rvfi_valid, 0);
        complete(1, 39);
        cyc();
        complete(0, 32);
        cyc();
        idle();
        cyc();
        chk_ret("t4.r0", 0, 32);
        cyc();
        chk_ret("t4.r1", 1, 31);
        check("t4.err_end", err, 1);

`ifdef RVFI_ROB_FLUSH_EN
        do_reset();
        alloc_n(3);
        complete(1, 40);
        cyc();
        idle();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("fl.noret", rvfi_valid, 0);
        check("fl.ready", alloc_ready, 1);
        t = alloc_tag;
        alloc_valid = 1'b1;
        cyc();
        idle();
        complete(int'(t), 41);
        cyc();
        idle();
        cyc();
        chk_ret("fl.r0", 0, 41);
        check("fl.err0", err, 0);
        complete(1, 42);
        cyc();
        idle();
        check("fl.late", err, 1);
`else
        t = '0;
        check("cfg.tag", {61'd0, t}, 0);
`endif

        // Asynchronous reset in the middle of a retire burst.
        do_reset();
        alloc_n(3);
        complete(0, 50);
        cyc();
        complete(1, 51);
        cyc();
        chk_ret("t6.r0", 0, 50);
        complete(2, 52);
        #2 resetn = 1'b0;
        idle();
        #1;
        check("t6.async_valid", rvfi_valid, 0);
        check("t6.async_order", rvfi_order, 0);
        check("t6.async_tag", alloc_tag, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        check("t6.err", err, 0);
        alloc_valid = 1'b1;
        check("t6.tag0", alloc_tag, 0);
        complete(0, 53);
        cyc();
        idle();
        cyc();
        chk_ret("t6.r0b", 0, 53);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
